// File: rtl/axi4_lite_lstm_sequencer.sv
// rtl/axi4_lite_lstm_sequencer.sv - AXI4-Lite master that streams a sequence into the LSTM slave and returns its result
module axi4_lite_lstm_sequencer #(
    parameter int          WIDTH       = 32,
    parameter int          DEPTH       = 512,
    parameter logic [31:0] INPUT_BASE  = 32'h0000_0000,
    parameter logic [31:0] START_ADDR  = 32'h0000_1000,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_1004,
    parameter logic [31:0] RESULT_ADDR = 32'h0000_1008,
    parameter int          POLL_LIMIT  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    // input sequence stream
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    // result stream
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    // AXI4-Lite write address
    output logic [31:0]      awaddr,
    output logic [2:0]       awprot,
    output logic             awvalid,
    input  logic             awready,
    // AXI4-Lite write data
    output logic [WIDTH-1:0] wdata,
    output logic [3:0]       wstrb,
    output logic             wvalid,
    input  logic             wready,
    // AXI4-Lite write response
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready,
    // AXI4-Lite read address
    output logic [31:0]      araddr,
    output logic [2:0]       arprot,
    output logic             arvalid,
    input  logic             arready,
    // AXI4-Lite read data
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    // sticky error flags, cleared only by reset
    output logic             err_resp,
    output logic             err_overflow,
    output logic             err_timeout
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;

    // WRITE/BRESP serve both input words and the start command; RADDR/RDATA
    // serve both status polls and the result read.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_BRESP  = 3'd2;
    localparam logic [2:0] ST_RADDR  = 3'd3;
    localparam logic [2:0] ST_RDATA  = 3'd4;
    localparam logic [2:0] ST_OUTPUT = 3'd5;

    logic [2:0]    state;
    logic [IW-1:0] index;
    logic [PW-1:0] poll_cnt;
    logic          cap_last;    // word in flight closes the sequence
    logic          wr_start;    // write in flight is the start command
    logic          rd_result;   // read in flight is the result read
    logic          at_end;
    logic          aw_fin;
    logic          w_fin;
    logic          poll_expired;

    assign at_end       = (index == IW'(DEPTH - 1));
    assign aw_fin       = !awvalid || awready;
    assign w_fin        = !wvalid || wready;
    assign poll_expired = (poll_cnt == PW'(POLL_LIMIT - 1));

    // Handshake readies decode directly from the state so they never lag it
    assign s_ready = (state == ST_IDLE);
    assign bready  = (state == ST_BRESP);
    assign rready  = (state == ST_RDATA);
    assign awprot  = 3'b000;
    assign arprot  = 3'b000;
    assign wstrb   = 4'hF;

    // Sequencer FSM: every AXI valid and address/data is registered so it stays stable until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            index        <= '0;
            poll_cnt     <= '0;
            cap_last     <= 1'b0;
            wr_start     <= 1'b0;
            rd_result    <= 1'b0;
            awaddr       <= '0;
            awvalid      <= 1'b0;
            wdata        <= '0;
            wvalid       <= 1'b0;
            araddr       <= '0;
            arvalid      <= 1'b0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            err_resp     <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        awaddr   <= INPUT_BASE + (32'(index) << 2);
                        wdata    <= s_data;
                        awvalid  <= 1'b1;
                        wvalid   <= 1'b1;
                        wr_start <= 1'b0;
                        // the last buffer slot always closes the sequence
                        cap_last <= s_last || at_end;
                        if (at_end && !s_last) begin
                            err_overflow <= 1'b1;
                        end
                        state <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_fin && w_fin) begin
                        state <= ST_BRESP;
                    end
                end

                ST_BRESP: begin
                    if (bvalid) begin
                        if (bresp != 2'b00) begin
                            err_resp <= 1'b1;
                        end
                        if (wr_start) begin
                            wr_start  <= 1'b0;
                            poll_cnt  <= '0;
                            rd_result <= 1'b0;
                            araddr    <= STATUS_ADDR;
                            arvalid   <= 1'b1;
                            state     <= ST_RADDR;
                        end else if (cap_last) begin
                            index    <= '0;
                            cap_last <= 1'b0;
                            wr_start <= 1'b1;
                            awaddr   <= START_ADDR;
                            wdata    <= WIDTH'(1);
                            awvalid  <= 1'b1;
                            wvalid   <= 1'b1;
                            state    <= ST_WRITE;
                        end else begin
                            index <= index + 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_RADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= ST_RDATA;
                    end
                end

                ST_RDATA: begin
                    if (rvalid) begin
                        if (rresp != 2'b00) begin
                            err_resp <= 1'b1;
                        end
                        if (rd_result) begin
                            m_data    <= rdata;
                            m_valid   <= 1'b1;
                            rd_result <= 1'b0;
                            state     <= ST_OUTPUT;
                        end else if (rdata[0]) begin
                            rd_result <= 1'b1;
                            araddr    <= RESULT_ADDR;
                            arvalid   <= 1'b1;
                            state     <= ST_RADDR;
                        end else if (poll_expired) begin
                            // give up on this sequence without producing a result
                            err_timeout <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            arvalid  <= 1'b1;
                            state    <= ST_RADDR;
                        end
                    end
                end

                ST_OUTPUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_lstm_sequencer.sv
// tb/tb_axi4_lite_lstm_sequencer.sv - directed bench for axi4_lite_lstm_sequencer with a small AXI4-Lite slave model
module tb_axi4_lite_lstm_sequencer;

    localparam int DEPTH = 4;
    localparam int PLIM  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        err_resp;
    logic        err_overflow;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    // slave configuration, written only by the test sequence
    int          aw_lat, w_lat, b_lat, err_word, status_zeros;
    bit          status_never;
    logic [31:0] result_val;

    // slave state
    int          aw_wait, w_wait, b_wait, wr_count, zeros_seen;
    bit          aw_taken, w_taken, ar_taken;
    logic [31:0] last_araddr;
    logic [31:0] wa_log[$];
    logic [31:0] wd_log[$];
    logic [31:0] ra_log[$];

    axi4_lite_lstm_sequencer #(
        .WIDTH(32), .DEPTH(DEPTH), .POLL_LIMIT(PLIM)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .err_resp(err_resp), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // slave outputs change on the falling edge, away from the DUT's sampling edge
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            bresp = 0; rresp = 0; rdata = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        end else begin
            if (awvalid && !aw_taken) begin
                awready = (aw_wait >= aw_lat);
                if (aw_wait < aw_lat) aw_wait++;
            end else begin
                awready = 0; aw_wait = 0;
            end
            if (wvalid && !w_taken) begin
                wready = (w_wait >= w_lat);
                if (w_wait < w_lat) w_wait++;
            end else begin
                wready = 0; w_wait = 0;
            end
            if (aw_taken && w_taken) begin
                bvalid = (b_wait >= b_lat);
                bresp  = (wr_count == err_word) ? 2'b10 : 2'b00;
                if (b_wait < b_lat) b_wait++;
            end else begin
                bvalid = 0; b_wait = 0; bresp = 0;
            end
            arready = arvalid && !ar_taken;
            rvalid  = ar_taken;
            rresp   = 2'b00;
            if (last_araddr == 32'h1004)
                rdata = (status_never || zeros_seen < status_zeros) ? 32'h0 : 32'h1;
            else
                rdata = result_val;
        end
    end

    // handshake monitor: records what the slave accepted
    always @(posedge clk) begin
        if (rst) begin
            aw_taken = 0; w_taken = 0; ar_taken = 0; wr_count = 0; zeros_seen = 0;
            last_araddr = 0;
            wa_log.delete(); wd_log.delete(); ra_log.delete();
        end else begin
            if (awvalid && awready) begin aw_taken = 1; wa_log.push_back(awaddr); end
            if (wvalid && wready) begin w_taken = 1; wd_log.push_back(wdata); end
            if (bvalid && bready) begin aw_taken = 0; w_taken = 0; wr_count++; end
            if (arvalid && arready) begin ar_taken = 1; last_araddr = araddr; ra_log.push_back(araddr); end
            if (rvalid && rready) begin
                ar_taken = 0;
                if (last_araddr == 32'h1004) zeros_seen++;
            end
        end
    end

    function automatic bit q_eq(input logic [31:0] a[$], input logic [31:0] b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return 0;
        return 1;
    endfunction

    task automatic do_reset();
        aw_lat = 0; w_lat = 0; b_lat = 0; err_word = -1; status_zeros = 0;
        status_never = 0; result_val = 32'h0;
        @(negedge clk);
        rst = 1; s_valid = 0; s_last = 0; m_ready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int n = 0;
        s_data = d; s_last = l; s_valid = 1;
        while (!s_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL send_word timeout data=%h s_ready=%b required 1", d, s_ready);
        end
        @(negedge clk);
        s_valid = 0; s_last = 0;
    endtask

    task automatic wait_mvalid();
        int n = 0;
        while (!m_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_mvalid timeout m_valid=%b required 1", m_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({awvalid, wvalid, arvalid, m_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valids aw/w/ar/m=%b required 0000", {awvalid, wvalid, arvalid, m_valid});
        end
        checks++;
        if ({err_resp, err_overflow, err_timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b required 000", {err_resp, err_overflow, err_timeout});
        end
        checks++;
        if (s_ready !== 1'b1 || awprot !== 3'b000 || arprot !== 3'b000 || wstrb !== 4'hF) begin
            errors++;
            $display("FAIL reset_idle s_ready=%b awprot=%h arprot=%h wstrb=%h required 1 0 0 f", s_ready, awprot, arprot, wstrb);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ewa[$], ewd[$], era[$];
        do_reset();
        result_val = 32'hABCD;
        send_word(32'h11, 0);
        send_word(32'h22, 0);
        send_word(32'h33, 1);
        wait_mvalid();
        checks++;
        if (m_data !== 32'hABCD) begin
            errors++;
            $display("FAIL basic_mdata got=%h required 0000abcd", m_data);
        end
        ewa = '{32'h0, 32'h4, 32'h8, 32'h1000};
        ewd = '{32'h11, 32'h22, 32'h33, 32'h1};
        era = '{32'h1004, 32'h1008};
        checks++;
        if (!q_eq(wa_log, ewa)) begin
            errors++;
            $display("FAIL basic_waddr got=%p required %p", wa_log, ewa);
        end
        checks++;
        if (!q_eq(wd_log, ewd)) begin
            errors++;
            $display("FAIL basic_wdata got=%p required %p", wd_log, ewd);
        end
        checks++;
        if (!q_eq(ra_log, era)) begin
            errors++;
            $display("FAIL basic_raddr got=%p required %p", ra_log, era);
        end
        checks++;
        if ({err_resp, err_overflow, err_timeout} !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags got=%b required 000", {err_resp, err_overflow, err_timeout});
        end
        m_ready = 1;
        @(negedge clk);
        m_ready = 0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_skew();
        logic [31:0] ewa[$];
        do_reset();
        aw_lat = 2; b_lat = 5; result_val = 32'h77;
        send_word(32'h5, 0);
        @(negedge clk);
        checks++;
        if (wvalid !== 1'b0 || awvalid !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL skew_wfirst wvalid=%b awvalid=%b s_ready=%b required 0 1 0", wvalid, awvalid, s_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (awvalid !== 1'b0 || s_ready !== 1'b0 || bready !== 1'b1) begin
            errors++;
            $display("FAIL skew_bwait awvalid=%b s_ready=%b bready=%b required 0 0 1", awvalid, s_ready, bready);
        end
        send_word(32'h6, 1);
        wait_mvalid();
        ewa = '{32'h0, 32'h4, 32'h1000};
        checks++;
        if (!q_eq(wa_log, ewa) || wd_log.size() != 3) begin
            errors++;
            $display("FAIL skew_writes got=%p wd_count=%0d required %p 3", wa_log, wd_log.size(), ewa);
        end
        checks++;
        if (m_data !== 32'h77) begin
            errors++;
            $display("FAIL skew_mdata got=%h required 00000077", m_data);
        end
        m_ready = 1;
        @(negedge clk);
        m_ready = 0;
    endtask

    task automatic test_poll();
        logic [31:0] era[$];
        do_reset();
        status_zeros = 3; result_val = 32'h1234;
        send_word(32'h9, 1);
        wait_mvalid();
        era = '{32'h1004, 32'h1004, 32'h1004, 32'h1004, 32'h1008};
        checks++;
        if (!q_eq(ra_log, era)) begin
            errors++;
            $display("FAIL poll_reads got=%p required %p", ra_log, era);
        end
        checks++;
        if (m_data !== 32'h1234 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL poll_result m_data=%h err_timeout=%b required 00001234 0", m_data, err_timeout);
        end
        m_ready = 1;
        @(negedge clk);
        m_ready = 0;
    endtask

    task automatic test_timeout();
        int n = 0;
        bit mv_seen = 0;
        do_reset();
        status_never = 1;
        send_word(32'h9, 1);
        while (!err_timeout && n < 400) begin
            if (m_valid) mv_seen = 1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag got=%b required 1", err_timeout);
        end
        checks++;
        if (ra_log.size() != PLIM || mv_seen || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_reads reads=%0d m_valid_seen=%0d required %0d 0", ra_log.size(), mv_seen | m_valid, PLIM);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_idle s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ewa[$], ewd[$];
        do_reset();
        result_val = 32'hBEEF;
        for (int i = 1; i <= 4; i++) send_word(32'hA0 + 32'(i), 0);
        wait_mvalid();
        checks++;
        if (err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag got=%b required 1", err_overflow);
        end
        m_ready = 1;
        @(negedge clk);
        m_ready = 0;
        send_word(32'hA5, 0);
        send_word(32'hA6, 0);
        repeat (6) @(negedge clk);
        ewa = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h1000, 32'h0, 32'h4};
        ewd = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h1, 32'hA5, 32'hA6};
        checks++;
        if (!q_eq(wa_log, ewa)) begin
            errors++;
            $display("FAIL overflow_waddr got=%p required %p", wa_log, ewa);
        end
        checks++;
        if (!q_eq(wd_log, ewd)) begin
            errors++;
            $display("FAIL overflow_wdata got=%p required %p", wd_log, ewd);
        end
    endtask

    task automatic test_bresp();
        do_reset();
        err_word = 1; result_val = 32'hC0DE;
        send_word(32'h1, 0);
        send_word(32'h2, 0);
        send_word(32'h3, 1);
        wait_mvalid();
        checks++;
        if (err_resp !== 1'b1 || err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL bresp_flags err_resp=%b err_overflow=%b required 1 0", err_resp, err_overflow);
        end
        checks++;
        if (m_data !== 32'hC0DE || wa_log.size() != 4) begin
            errors++;
            $display("FAIL bresp_result m_data=%h writes=%0d required 0000c0de 4", m_data, wa_log.size());
        end
        m_ready = 1;
        @(negedge clk);
        m_ready = 0;
    endtask

    task automatic test_backpressure();
        do_reset();
        result_val = 32'h5A5A_5A5A;
        send_word(32'h44, 1);
        wait_mvalid();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'h5A5A_5A5A || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d m_valid=%b m_data=%h s_ready=%b required 1 5a5a5a5a 0", i, m_valid, m_data, s_ready);
            end
            @(negedge clk);
        end
        m_ready = 1;
        @(negedge clk);
        m_ready = 0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        err_word = 0;
        send_word(32'h1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (err_resp !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre err_resp=%b required 1", err_resp);
        end
        aw_lat = 20;
        send_word(32'h2, 0);
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_inwrite awvalid=%b wvalid=%b required 1 1", awvalid, wvalid);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || {err_resp, err_overflow, err_timeout} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_clear awvalid=%b wvalid=%b flags=%b required 0 0 000", awvalid, wvalid, {err_resp, err_overflow, err_timeout});
        end
        repeat (2) @(negedge clk);
        rst = 0;
        aw_lat = 0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || awvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle s_ready=%b awvalid=%b required 1 0", s_ready, awvalid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_poll();
        test_timeout();
        test_overflow();
        test_bresp();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_lstm_sequencer.md
Name: axi4_lite_lstm_sequencer

Overview:
- AXI4-Lite master that sits directly upstream of the LSTM layers AXI4-Lite slave and drives its register space.
- Accepts one input sequence on a valid/ready stream and writes each word into the slave's input buffer.
- Then writes the start register, polls the status register until done, reads the result word and presents it on an output stream.

Parameters:
- WIDTH, 32: data width of stream and AXI data; fixed at 32.
- DEPTH, 512: maximum words per sequence.
- INPUT_BASE, 32'h0000_0000: byte address of input word 0; word i goes to INPUT_BASE + 4*i.
- START_ADDR, 32'h0000_1000: writing 1 here starts the LSTM.
- STATUS_ADDR, 32'h0000_1004: bit0 = done.
- RESULT_ADDR, 32'h0000_1008: result word.
- POLL_LIMIT, 1024: maximum status reads before timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_data  in  32  input sample
- s_valid  in  1  sample valid
- s_last  in  1  final sample of sequence
- s_ready  out  1  sequencer accepts sample
- m_data  out  32  result word
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- awaddr  out  32  write address
- awprot  out  3  constant 3'b000
- awvalid  out  1  write address valid
- awready  in  1  write address accepted
- wdata  out  32  write data
- wstrb  out  4  constant 4'hF
- wvalid  out  1  write data valid
- wready  in  1  write data accepted
- bresp  in  2  write response
- bvalid  in  1  write response valid
- bready  out  1  response accepted
- araddr  out  32  read address
- arprot  out  3  constant 3'b000
- arvalid  out  1  read address valid
- arready  in  1  read address accepted
- rdata  in  32  read data
- rresp  in  2  read response
- rvalid  in  1  read data valid
- rready  out  1  read data accepted
- err_resp  out  1  sticky: any bresp/rresp != 2'b00
- err_overflow  out  1  sticky: DEPTH words seen without s_last
- err_timeout  out  1  sticky: POLL_LIMIT reached

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; index counter 0; poll counter 0; sticky flags cleared. The sticky flags clear only on reset.
- IDLE:
  - s_ready = 1.
  - On s_valid & s_ready, capture s_data, the address INPUT_BASE + 4*index, and the last flag, then go to WRITE.
  - Forced last: if index == DEPTH-1 and s_last == 0, treat the word as last and set err_overflow.
- WRITE:
  - awvalid and wvalid assert the cycle after capture and are held stable until their respective ready is sampled high.
  - AW and W complete independently, in either order or the same cycle.
  - When both are done, go to BRESP.
- BRESP:
  - bready = 1. On bvalid, set err_resp if bresp != 0.
  - If the captured word was last: go to START (index cleared). Otherwise increment index and return to IDLE.
  - Minimum one sample per 3 cycles.
- START: same write procedure as WRITE/BRESP with awaddr = START_ADDR and wdata = 1. Then go to POLL.
- POLL:
  - arvalid with araddr = STATUS_ADDR, held until arready; then rready = 1 until rvalid.
  - On rvalid, set err_resp if rresp != 0.
  - rdata[0] == 1: go to RESULT.
  - Otherwise increment the poll counter. If it reaches POLL_LIMIT, set err_timeout and return to IDLE with no output; else reissue the read the next cycle.
  - The poll counter clears on entry to POLL.
- RESULT:
  - Read RESULT_ADDR using the same read handshake.
  - On rvalid, register rdata into m_data, set m_valid, and go to OUTPUT.
- OUTPUT: hold m_data and m_valid stable until m_ready; then clear m_valid and return to IDLE.
- s_ready is 0 in every state except IDLE, so no input is accepted during a transaction.
- Valid never drops before its ready. Address and data are never changed while valid is high.
- Error responses never abort the sequence; the sequencer continues.
- Only one outstanding AXI transaction at a time.
- Reset mid-transaction drops all valids immediately (asynchronous). No recovery of a partial sequence.

Test Plan:
- 3-word sequence 0x11, 0x22, 0x33 (last on third); slave always ready; status done on first poll; rdata 0xABCD -> writes to 0x0, 0x4, 0x8, then 0x1000 = 1, a read of 0x1004, a read of 0x1008; m_data = 0xABCD with m_valid; no error flags.
- Slave asserts wready 2 cycles before awready, and bvalid delayed 5 cycles -> wvalid drops after wready while awvalid is held; exactly one write per word; s_ready stays 0 until the response.
- Status returns 0 three times then 1 -> exactly 4 status reads, then the result read. With POLL_LIMIT = 4 and status never 1 -> err_timeout = 1, m_valid never asserted, state returns to IDLE.
- DEPTH = 4, six words with no s_last -> the 4th word (address 0xC) is treated as last and err_overflow = 1; the START write follows; words 5 and 6 start a new sequence at address 0x0.
- bresp = 2'b10 on word 2 -> err_resp = 1; the sequence completes and the result is still delivered.
- m_ready held low for 10 cycles -> m_data and m_valid stable throughout, s_ready stays 0. Assert rst during WRITE -> awvalid and wvalid are 0 immediately and all flags clear.
